hms_display_scan: RTL and testbench

// - Downstream consumer of the clock-time counter's hours/minutes/seconds outputs (6-bit binary each).
// - Converts each value to two BCD digits and drives a 6-digit time-multiplexed 7-segment display (HH MM SS).
// - Scans one digit at a time; the input time is snapshotted once per full scan so a frame never tears.

---
 rtl/hms_display_scan.sv | 239 +++++++++++++++++++++++
 tb/tb_hms_display_scan.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hms_display_scan.sv
// -----------------------------------------------------------------------------
// hms_display_scan
//
// Purpose:
//   Takes the binary hours/minutes/seconds from the clock-time counter and
//   drives a 6-digit time-multiplexed 7-segment display laid out HH MM SS.
//   One digit is lit at a time. The input time is copied into a snapshot
//   once per full scan, so a displayed frame never mixes two different times.
//
// Parameters:
//   SCAN_DIV        clk cycles per digit slot (>= 2)
//   SEG_ACTIVE_LOW  1 = invert seg outputs (common-anode)
//   DIG_ACTIVE_LOW  1 = invert digit_en outputs
//
// Ports:
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-high reset
//   hours      in   6  binary hours
//   minutes    in   6  binary minutes
//   seconds    in   6  binary seconds
//   seg        out  7  segments {g,f,e,d,c,b,a}, registered
//   digit_en   out  6  one-hot digit select, registered
//                      bit0 = seconds ones .. bit5 = hours tens
//   seg_oeb    out  7  pad output enables, tied 0
//   digit_oeb  out  6  pad output enables, tied 0
//
// Optional feature macro:
//   HMS_LZ_BLANK_EN  when defined, the hours-tens digit is blanked (seg all
//                    off, digit_en unchanged) while the snapshot hours tens
//                    digit is 0.
//
// Handshake:
//   There is no valid/ready interface. hours/minutes/seconds are sampled only
//   on the edge that ends the last digit slot of a scan; at all other times
//   they are ignored.
// -----------------------------------------------------------------------------
module hms_display_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [6:0] seg,
  output logic [5:0] digit_en,
  output logic [6:0] seg_oeb,
  output logic [5:0] digit_oeb
);

  localparam int            PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'd5;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    logic [5:0] q;
    q = v / 6'd10;
    return q[3:0];
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    logic [5:0] r;
    r = v % 6'd10;
    return r[3:0];
  endfunction

  // Active-high segment patterns {g,f,e,d,c,b,a}. Codes above 9 cannot occur
  // from a 6-bit value split into tens/ones, but decode to blank for safety.
  function automatic logic [6:0] seg_rom(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Slot prescaler: tick marks the last cycle of every digit slot.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] prescale;
  logic          tick;

  assign tick = (prescale == PS_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
    end else if (tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit scan sequencer (state = digit index 0..5)
  // ---------------------------------------------------------------------------
  logic [2:0] idx;
  logic [2:0] idx_next;
  logic       frame_end;   // last slot of the scan is ending this cycle

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= 3'd0;
    end else begin
      idx <= idx_next;
    end
  end

  // Next-state logic
  always_comb begin
    idx_next = idx;
    if (tick) begin
      if (idx == IDX_LAST) begin
        idx_next = 3'd0;
      end else begin
        idx_next = idx + 3'd1;
      end
    end
  end

  // Output logic of the sequencer
  always_comb begin
    frame_end = 1'b0;
    if (tick && (idx == IDX_LAST)) begin
      frame_end = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Time snapshot, updated on the same edge the index wraps back to digit 0.
  // ---------------------------------------------------------------------------
  logic [5:0] snap_h;
  logic [5:0] snap_m;
  logic [5:0] snap_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_h <= 6'd0;
      snap_m <= 6'd0;
      snap_s <= 6'd0;
    end else if (frame_end) begin
      snap_h <= hours;
      snap_m <= minutes;
      snap_s <= seconds;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection and decode for the current index
  // ---------------------------------------------------------------------------
  logic [3:0] h_tens;
  logic [3:0] digit_val;
  logic       blank;
  logic [6:0] seg_next;
  logic [5:0] en_next;
  logic       tick_d;      // first cycle of a new slot

  assign h_tens = bcd_tens(snap_h);

  always_comb begin
    digit_val = 4'd0;
    case (idx)
      3'd0:    digit_val = bcd_ones(snap_s);
      3'd1:    digit_val = bcd_tens(snap_s);
      3'd2:    digit_val = bcd_ones(snap_m);
      3'd3:    digit_val = bcd_tens(snap_m);
      3'd4:    digit_val = bcd_ones(snap_h);
      3'd5:    digit_val = h_tens;
      default: digit_val = 4'd0;
    endcase
  end

`ifdef HMS_LZ_BLANK_EN
  // Only the hours-tens digit is ever blanked.
  assign blank = (idx == IDX_LAST) && (h_tens == 4'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_next = 7'h00;
    if (!blank) begin
      seg_next = seg_rom(digit_val);
    end
  end

  // Ghost guard: the segment register loads the new digit's pattern on the
  // first edge of a slot while the digit enables are held off for that one
  // cycle, so the previous digit's drivers never see the new pattern.
  always_comb begin
    en_next = 6'd1 << idx;
    if (tick_d) begin
      en_next = 6'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers (active-high internally)
  // ---------------------------------------------------------------------------
  logic [6:0] seg_r;
  logic [5:0] en_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_d <= 1'b0;
      seg_r  <= 7'h00;
      en_r   <= 6'h00;
    end else begin
      tick_d <= tick;
      seg_r  <= seg_next;
      en_r   <= en_next;
    end
  end

  // Polarity is applied after the registers so reset yields the inactive level.
  assign seg      = SEG_ACTIVE_LOW ? ~seg_r : seg_r;
  assign digit_en = DIG_ACTIVE_LOW ? ~en_r  : en_r;

  assign seg_oeb   = 7'h00;
  assign digit_oeb = 6'h00;

endmodule

// File: tb/tb_hms_display_scan.sv
// -----------------------------------------------------------------------------
// tb_hms_display_scan
//
// Directed bench for hms_display_scan with SCAN_DIV=4. Two instances share
// clock, reset and time inputs: an active-high one and one with both outputs
// inverted. Inputs change and outputs are sampled on the falling clock edge.
// Edge numbering after a reset release: slot n drives its outputs from rising
// edge 4n+1 to 4n+4; the first edge of every slot except slot 0 has
// digit_en off.
// -----------------------------------------------------------------------------
module tb_hms_display_scan;

  logic       clk;
  logic       reset;
  logic [5:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;

  logic [6:0] seg;
  logic [5:0] digit_en;
  logic [6:0] seg_oeb;
  logic [5:0] digit_oeb;

  logic [6:0] seg_inv;
  logic [5:0] digit_en_inv;
  logic [6:0] seg_oeb_inv;
  logic [5:0] digit_oeb_inv;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Expected frames, packed {d5,d4,d3,d2,d1,d0}, 7 bits per digit.
  localparam logic [41:0] F_000000 = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  localparam logic [41:0] F_123456 = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
  localparam logic [41:0] F_123457 = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h07};
  localparam logic [41:0] F_630009 = {7'h7D, 7'h4F, 7'h3F, 7'h3F, 7'h3F, 7'h6F};
`ifdef HMS_LZ_BLANK_EN
  localparam logic [41:0] F_070509 = {7'h00, 7'h07, 7'h3F, 7'h6D, 7'h3F, 7'h6F};
`else
  localparam logic [41:0] F_070509 = {7'h3F, 7'h07, 7'h3F, 7'h6D, 7'h3F, 7'h6F};
`endif
  localparam logic [41:0] F_170509 = {7'h06, 7'h07, 7'h3F, 7'h6D, 7'h3F, 7'h6F};

  hms_display_scan #(
    .SCAN_DIV      (4),
    .SEG_ACTIVE_LOW(1'b0),
    .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .seg      (seg),
    .digit_en (digit_en),
    .seg_oeb  (seg_oeb),
    .digit_oeb(digit_oeb)
  );

  hms_display_scan #(
    .SCAN_DIV      (4),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut_inv (
    .clk      (clk),
    .reset    (reset),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .seg      (seg_inv),
    .digit_en (digit_en_inv),
    .seg_oeb  (seg_oeb_inv),
    .digit_oeb(digit_oeb_inv)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual=running required=finished)");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic next_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    hours   = h;
    minutes = m;
    seconds = s;
  endtask

  // One full digit slot starting from the falling edge just before its first
  // output edge. Checks the ghost cycle and the three lit cycles on both DUTs.
  task automatic check_slot(input logic [6:0] exp_seg, input int d);
    logic [5:0] exp_en;
    exp_en = 6'(1 << d);
    next_edge();
    total_cnt++;
    if (seg !== exp_seg || digit_en !== 6'h00) begin
      $display("FAIL ghost d%0d: seg=%h digit_en=%h required seg=%h digit_en=00",
               d, seg, digit_en, exp_seg);
    end else pass_cnt++;
    total_cnt++;
    if (seg_inv !== ~exp_seg || digit_en_inv !== 6'h3F) begin
      $display("FAIL ghost_inv d%0d: seg=%h digit_en=%h required seg=%h digit_en=3f",
               d, seg_inv, digit_en_inv, ~exp_seg);
    end else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      next_edge();
      total_cnt++;
      if (seg !== exp_seg || digit_en !== exp_en) begin
        $display("FAIL lit d%0d c%0d: seg=%h digit_en=%h required seg=%h digit_en=%h",
                 d, c, seg, digit_en, exp_seg, exp_en);
      end else pass_cnt++;
      total_cnt++;
      if (seg_inv !== ~exp_seg || digit_en_inv !== ~exp_en) begin
        $display("FAIL lit_inv d%0d c%0d: seg=%h digit_en=%h required seg=%h digit_en=%h",
                 d, c, seg_inv, digit_en_inv, ~exp_seg, ~exp_en);
      end else pass_cnt++;
    end
  endtask

  task automatic run_frame(input logic [41:0] frame);
    for (int d = 0; d < 6; d++) begin
      check_slot(frame[d*7 +: 7], d);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1;
    total_cnt++;
    if (seg !== 7'h00 || digit_en !== 6'h00) begin
      $display("FAIL reset_initial: seg=%h digit_en=%h required seg=00 digit_en=00", seg, digit_en);
    end else pass_cnt++;
    total_cnt++;
    if (seg_oeb !== 7'h00 || digit_oeb !== 6'h00 || seg_oeb_inv !== 7'h00 || digit_oeb_inv !== 6'h00) begin
      $display("FAIL oeb: seg_oeb=%h digit_oeb=%h required 00 00", seg_oeb, digit_oeb);
    end else pass_cnt++;

    // Run long enough for a snapshot of 12:34:56 to be taken, then reset
    // asynchronously between clock edges.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) next_edge();
    total_cnt++;
    if (digit_en === 6'h00) begin
      $display("FAIL pre_reset_active: digit_en=%h required nonzero", digit_en);
    end else pass_cnt++;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total_cnt++;
    if (seg !== 7'h00 || digit_en !== 6'h00) begin
      $display("FAIL reset_async: seg=%h digit_en=%h required seg=00 digit_en=00", seg, digit_en);
    end else pass_cnt++;
    total_cnt++;
    if (seg_inv !== 7'h7F || digit_en_inv !== 6'h3F) begin
      $display("FAIL reset_async_inv: seg=%h digit_en=%h required seg=7f digit_en=3f",
               seg_inv, digit_en_inv);
    end else pass_cnt++;

    @(negedge clk);
    reset = 1'b0;
    next_edge();
    total_cnt++;
    if (seg !== 7'h3F || digit_en !== 6'h01) begin
      $display("FAIL reset_first_out: seg=%h digit_en=%h required seg=3f digit_en=01", seg, digit_en);
    end else pass_cnt++;
    total_cnt++;
    if (seg_inv !== 7'h40 || digit_en_inv !== 6'h3E) begin
      $display("FAIL reset_first_out_inv: seg=%h digit_en=%h required seg=40 digit_en=3e",
               seg_inv, digit_en_inv);
    end else pass_cnt++;
    for (int i = 0; i < 3; i++) next_edge();
  endtask

  // Snapshot was cleared by reset: rest of frame 1 shows zeros, then 12:34:56.
  task automatic test_scan_order();
    for (int d = 1; d < 6; d++) begin
      check_slot(7'h3F, d);
    end
    run_frame(F_123456);
  endtask

  // Seconds change while digit 2 is scanned; only the next frame shows it.
  task automatic test_tear_free();
    for (int d = 0; d < 6; d++) begin
      if (d == 2) seconds = 6'd57;
      check_slot(F_123456[d*7 +: 7], d);
    end
    run_frame(F_123457);
  endtask

  task automatic test_wrap_range();
    set_time(6'd63, 6'd0, 6'd9);
    run_frame(F_123457);
    run_frame(F_630009);
  endtask

  task automatic test_lz_blank();
    set_time(6'd7, 6'd5, 6'd9);
    run_frame(F_630009);
    hours = 6'd17;
    run_frame(F_070509);
    run_frame(F_170509);
  endtask

  // Inputs wiggling without a frame boundary have no effect; back-to-back
  // frames with steady inputs repeat exactly.
  task automatic test_back_to_back();
    for (int d = 0; d < 6; d++) begin
      seconds = 6'($urandom_range(0, 63));
      minutes = 6'($urandom_range(0, 63));
      if (d == 5) set_time(6'd0, 6'd0, 6'd0);
      check_slot(F_170509[d*7 +: 7], d);
    end
    run_frame(F_000000);
  endtask

  initial begin
    reset = 1'b1;
    set_time(6'd12, 6'd34, 6'd56);
    test_reset();
    test_scan_order();
    test_tear_free();
    test_wrap_range();
    test_lz_blank();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
